// File: rtl/spike_current_accumulator_pkg.sv
// Shared definitions for the spike current accumulator.
//  - Fixed-point format: 17-bit sign-magnitude, bit 16 = sign,
//    [15:8] = integer, [7:0] = fraction.
//  - Saturation limits and the canonical zero (+0).
//  - FSM state encoding.
package spike_current_accumulator_pkg;

  localparam int FX_W    = 17;
  localparam int FX_FRAC = 8;
  localparam int FX_SIGN = 16;

  typedef logic [FX_W-1:0] fx_t;

  localparam fx_t FX_MAX_POS = 17'h0FFFF;
  localparam fx_t FX_MAX_NEG = 17'h1FFFF;
  localparam fx_t FX_ZERO    = 17'h00000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/sm_sat_add.sv
// Combinational saturating adder for 17-bit sign-magnitude values.
//  Ports:
//   a, b  in   17  sign-magnitude operands
//   sum   out  17  saturated sum; a zero result is always +0
module sm_sat_add
  import spike_current_accumulator_pkg::*;
(
  input  fx_t a,
  input  fx_t b,
  output fx_t sum
);

  logic [FX_SIGN:0]   mag_sum;
  logic [FX_SIGN-1:0] mag;
  logic               sgn;

  always_comb begin
    mag_sum = '0;
    mag     = '0;
    sgn     = 1'b0;
    if (a[FX_SIGN] == b[FX_SIGN]) begin
      // Like signs: magnitudes add, a carry out of 16 bits clamps.
      mag_sum = {1'b0, a[FX_SIGN-1:0]} + {1'b0, b[FX_SIGN-1:0]};
      mag     = mag_sum[FX_SIGN] ? FX_MAX_POS[FX_SIGN-1:0] : mag_sum[FX_SIGN-1:0];
      sgn     = a[FX_SIGN];
    end else if (a[FX_SIGN-1:0] >= b[FX_SIGN-1:0]) begin
      mag = a[FX_SIGN-1:0] - b[FX_SIGN-1:0];
      sgn = a[FX_SIGN];
    end else begin
      mag = b[FX_SIGN-1:0] - a[FX_SIGN-1:0];
      sgn = b[FX_SIGN];
    end
    // Never emit -0.
    sum = (mag == '0) ? FX_ZERO : {sgn, mag};
  end

endmodule

// File: rtl/spike_current_accumulator.sv
// Spike current accumulator.
//  Each accepted spike from source s walks all N destinations, one per
//  cycle, adding w[s][d] into the accumulate bank. A timestep request
//  swaps the accumulate and read banks; the read bank feeds i_out.
//  Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cfg_we/src/dst/weight, cfg_ready    weight write port (IDLE only)
//   spike_valid/id, spike_ready   spike handshake
//   step_req (level), step_ack (one-cycle pulse)   timestep boundary
//   rd_id, i_out                  combinational read of the read bank
//   busy                          high while scanning
module spike_current_accumulator
  import spike_current_accumulator_pkg::*;
#(
  parameter int N_NEURONS = 16,
  parameter int ID_W      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [ID_W-1:0] cfg_src,
  input  logic [ID_W-1:0] cfg_dst,
  input  logic [FX_W-1:0] cfg_weight,
  output logic            cfg_ready,
  input  logic            spike_valid,
  input  logic [ID_W-1:0] spike_id,
  output logic            spike_ready,
  input  logic            step_req,
  output logic            step_ack,
  input  logic [ID_W-1:0] rd_id,
  output logic [FX_W-1:0] i_out,
  output logic            busy
);

  fx_t             w_reg    [N_NEURONS*N_NEURONS];
  fx_t             bank_reg [2][N_NEURONS];
  state_t          state_reg;
  logic [ID_W-1:0] src_reg;
  logic [ID_W-1:0] dst_reg;
  logic            bank_sel_reg;   // selects the read bank
  logic            step_ack_reg;

  logic            acc_sel;
  fx_t             add_a;
  fx_t             add_b;
  fx_t             add_sum;

  assign acc_sel     = ~bank_sel_reg;
  assign add_a       = bank_reg[acc_sel][dst_reg];
  assign add_b       = w_reg[{src_reg, dst_reg}];

  assign cfg_ready   = (state_reg == ST_IDLE);
  assign spike_ready = (state_reg == ST_IDLE) && !step_req;
  assign busy        = (state_reg == ST_SCAN);
  assign step_ack    = step_ack_reg;
  assign i_out       = bank_reg[bank_sel_reg][rd_id];

  sm_sat_add u_add (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS*N_NEURONS; k++) w_reg[k] <= FX_ZERO;
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < N_NEURONS; k++) bank_reg[b][k] <= FX_ZERO;
      state_reg    <= ST_IDLE;
      src_reg      <= '0;
      dst_reg      <= '0;
      bank_sel_reg <= 1'b0;
      step_ack_reg <= 1'b0;
    end else begin
      step_ack_reg <= 1'b0;
      // A write in the same cycle as a spike lands before the scan reads it.
      if (cfg_we && state_reg == ST_IDLE)
        w_reg[{cfg_src, cfg_dst}] <= cfg_weight;
      case (state_reg)
        ST_IDLE: begin
          // step_req is still high during the ack cycle; the ack guard
          // keeps one request from swapping twice.
          if (step_req && !step_ack_reg) begin
            bank_sel_reg <= ~bank_sel_reg;
            for (int k = 0; k < N_NEURONS; k++)
              bank_reg[bank_sel_reg][k] <= FX_ZERO;
            step_ack_reg <= 1'b1;
          end else if (spike_valid && spike_ready) begin
            src_reg   <= spike_id;
            dst_reg   <= '0;
            state_reg <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          bank_reg[acc_sel][dst_reg] <= add_sum;
          dst_reg <= dst_reg + 1'b1;
          if (dst_reg == ID_W'(N_NEURONS-1)) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_current_accumulator.sv
module tb_spike_current_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_src = '0;
  logic [3:0]  cfg_dst = '0;
  logic [16:0] cfg_weight = '0;
  logic        cfg_ready;
  logic        spike_valid = 1'b0;
  logic [3:0]  spike_id = '0;
  logic        spike_ready;
  logic        step_req = 1'b0;
  logic        step_ack;
  logic [3:0]  rd_id = '0;
  logic [16:0] i_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model: plain signed integers, clamped per addition.
  int w_m   [16][16];
  int acc_m [16];
  int rd_m  [16];

  always #5 clk = ~clk;

  spike_current_accumulator #(.N_NEURONS(16), .ID_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_src(cfg_src), .cfg_dst(cfg_dst),
    .cfg_weight(cfg_weight), .cfg_ready(cfg_ready),
    .spike_valid(spike_valid), .spike_id(spike_id), .spike_ready(spike_ready),
    .step_req(step_req), .step_ack(step_ack),
    .rd_id(rd_id), .i_out(i_out), .busy(busy)
  );

  function automatic int sm2int(logic [16:0] v);
    return v[16] ? -int'(v[15:0]) : int'(v[15:0]);
  endfunction

  function automatic int clampi(int x);
    if (x > 65535) return 65535;
    if (x < -65535) return -65535;
    return x;
  endfunction

  function automatic logic [16:0] int2sm(int x);
    if (x < 0) return {1'b1, 16'(-x)};
    return {1'b0, 16'(x)};
  endfunction

  task automatic check(string tag, logic [16:0] obs, logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int s = 0; s < 16; s++) begin
      for (int d = 0; d < 16; d++) w_m[s][d] = 0;
      acc_m[s] = 0;
      rd_m[s]  = 0;
    end
  endtask

  task automatic write_w(int s, int d, logic [16:0] v);
    cfg_src = 4'(s); cfg_dst = 4'(d); cfg_weight = v; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    w_m[s][d] = sm2int(v);
    $display("cfg  w[%0d][%0d] = %h", s, d, v);
  endtask

  // Handshake one spike and wait for its scan to finish.
  task automatic send_spike(int id, output int busy_cycles);
    int n;
    n = 0;
    while (!spike_ready && n < 50) begin tick(); n++; end
    spike_id = 4'(id); spike_valid = 1'b1;
    tick();
    spike_valid = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 40) begin tick(); busy_cycles++; end
    for (int d = 0; d < 16; d++) acc_m[d] = clampi(acc_m[d] + w_m[id][d]);
    $display("spike id=%0d busy_cycles=%0d", id, busy_cycles);
  endtask

  task automatic do_step(string tag);
    int n;
    n = 0;
    step_req = 1'b1;
    tick(); n++;
    while (!step_ack && n < 50) begin tick(); n++; end
    check({tag, "_ack_seen"}, step_ack, 1'b1);
    step_req = 1'b0;
    tick();
    check({tag, "_ack_pulse"}, step_ack, 1'b0);
    for (int d = 0; d < 16; d++) begin rd_m[d] = acc_m[d]; acc_m[d] = 0; end
    $display("step %s after %0d cycles", tag, n);
  endtask

  task automatic check_all(string tag);
    for (int r = 0; r < 16; r++) begin
      rd_id = 4'(r);
      #1;
      check($sformatf("%s_i%0d", tag, r), i_out, int2sm(rd_m[r]));
    end
  endtask

  task automatic read_i(int r, output logic [16:0] v);
    rd_id = 4'(r);
    #1;
    v = i_out;
  endtask

  initial begin
    int bc;
    int ack_in_scan;
    int n;
    logic [16:0] v;

    model_clear();

    // 1: reset state
    #23 rst_n = 1'b1;
    tick();
    check("rst_spike_ready", spike_ready, 1'b1);
    check("rst_cfg_ready", cfg_ready, 1'b1);
    check("rst_step_ack", step_ack, 1'b0);
    check("rst_busy", busy, 1'b0);
    check_all("rst");

    // 2: single spike
    write_w(2, 5, 17'h00180);
    send_spike(2, bc);
    check("single_busy_cycles", 17'(bc), 17'd16);
    do_step("single");
    read_i(5, v);
    check("single_i5", v, 17'h00180);
    check_all("single");

    // 3: mixed sign
    write_w(0, 3, 17'h00200);
    write_w(1, 3, 17'h10300);
    send_spike(0, bc);
    send_spike(1, bc);
    do_step("mixed");
    read_i(3, v);
    check("mixed_i3", v, 17'h10100);
    check_all("mixed");

    // 4: positive and negative saturation
    write_w(0, 7, 17'h0FF00);
    for (int k = 0; k < 3; k++) send_spike(0, bc);
    do_step("satp");
    read_i(7, v);
    check("satp_i7", v, 17'h0FFFF);
    write_w(0, 7, 17'h1FF00);
    for (int k = 0; k < 3; k++) send_spike(0, bc);
    do_step("satn");
    read_i(7, v);
    check("satn_i7", v, 17'h1FFFF);
    check_all("sat");

    // 5: exact cancellation gives +0
    write_w(4, 1, 17'h00100);
    write_w(6, 1, 17'h10100);
    send_spike(4, bc);
    send_spike(6, bc);
    do_step("cancel");
    read_i(1, v);
    check("cancel_i1", v, 17'h00000);

    // 6a: step_req raised three cycles into a scan
    write_w(9, 0, 17'h00040);
    write_w(9, 15, 17'h10020);
    n = 0;
    while (!spike_ready && n < 50) begin tick(); n++; end
    spike_id = 4'd9; spike_valid = 1'b1;
    tick();
    spike_valid = 1'b0;
    for (int d = 0; d < 16; d++) acc_m[d] = clampi(acc_m[d] + w_m[9][d]);
    tick(); tick(); tick();
    step_req = 1'b1;
    ack_in_scan = 0;
    n = 0;
    while (busy && n < 40) begin
      if (step_ack) ack_in_scan++;
      tick(); n++;
    end
    check("midstep_no_ack_in_scan", 17'(ack_in_scan), 17'd0);
    check("midstep_scan_rest", 17'(n), 17'd13);
    n = 0;
    while (!step_ack && n < 50) begin tick(); n++; end
    check("midstep_ack_seen", step_ack, 1'b1);
    check("midstep_ack_idle", busy, 1'b0);
    step_req = 1'b0;
    tick();
    check("midstep_ack_pulse", step_ack, 1'b0);
    for (int d = 0; d < 16; d++) begin rd_m[d] = acc_m[d]; acc_m[d] = 0; end
    $display("step midscan done");
    read_i(15, v);
    check("midstep_i15", v, 17'h10020);
    check_all("midstep");

    // 6b: reset pulsed mid-scan
    spike_id = 4'd9; spike_valid = 1'b1;
    tick();
    spike_valid = 1'b0;
    tick(); tick(); tick(); tick();
    check("rstmid_busy_before", busy, 1'b1);
    #2 rst_n = 1'b0;
    #2;
    check("rstmid_busy_in_rst", busy, 1'b0);
    #1 rst_n = 1'b1;
    model_clear();
    tick();
    $display("reset mid-scan");
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_spike_ready", spike_ready, 1'b1);
    check("rstmid_cfg_ready", cfg_ready, 1'b1);
    check_all("rstmid");

    // Random rounds against the model, including read-bank stability.
    for (int round = 0; round < 4; round++) begin
      for (int k = 0; k < 12; k++)
        write_w($urandom_range(0, 15), $urandom_range(0, 15), 17'($urandom));
      for (int k = 0; k < 5; k++) send_spike($urandom_range(0, 15), bc);
      check_all($sformatf("rnd%0d_hold", round));
      do_step($sformatf("rnd%0d", round));
      check_all($sformatf("rnd%0d", round));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
